ps2_host_tx: RTL



---
 rtl/ps2_host_tx.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter that drives the shared clock/data lines through pull-down enables.
// Define PS2_TX_TIMEOUT_EN to build the watchdog that aborts a transfer the device never finishes clocking.
module ps2_host_tx #(
    parameter int INHIBIT = 800,
    parameter int TIMEOUT = 140000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic [1:0] ps2,
    output logic       clkOe,
    output logic       datOe,
    input  logic [7:0] d,
    input  logic       wr,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_REQ     = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_PARITY  = 3'd4,
        ST_STOP    = 3'd5,
        ST_RELEASE = 3'd6
    } state_t;

    localparam int IW = (INHIBIT > 1) ? $clog2(INHIBIT) : 1;
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT - 1);

    state_t        state_q;
    logic [7:0]    clk_sh_q;
    logic          clk_f_q;
    logic          dat_q;
    logic [7:0]    byte_q;
    logic [3:0]    bit_cnt_q;
    logic [IW-1:0] inh_cnt_q;
    logic          clk_oe_q;
    logic          dat_oe_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          fall;

`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [17:0] TMO_LIMIT = 18'(TIMEOUT);
    logic [17:0] tmo_cnt_q;
`endif

    // Filtered clock is still high while the last eight samples are all low: that is the falling event.
    assign fall = clk_f_q & (clk_sh_q == 8'h00);

    // Request handshake: wr is taken on any ce cycle where the FSM is idle; busy is the
    // not-ready indication, and a wr seen while busy is dropped rather than queued.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            clk_sh_q  <= 8'hFF;
            clk_f_q   <= 1'b1;
            dat_q     <= 1'b1;
            byte_q    <= 8'h00;
            bit_cnt_q <= 4'd0;
            inh_cnt_q <= '0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else if (ce) begin
            clk_sh_q <= {clk_sh_q[6:0], ps2[0]};
            if (clk_sh_q == 8'hFF) begin
                clk_f_q <= 1'b1;
            end else if (clk_sh_q == 8'h00) begin
                clk_f_q <= 1'b0;
            end
            dat_q  <= ps2[1];
            done_q <= 1'b0;
            err_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    if (wr) begin
                        byte_q    <= d;
                        bit_cnt_q <= 4'd0;
                        inh_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        clk_oe_q  <= 1'b1;
                        state_q   <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    clk_oe_q <= 1'b1;
                    if (inh_cnt_q == INH_LAST) begin
                        dat_oe_q <= 1'b1;
                        state_q  <= ST_REQ;
                    end else begin
                        inh_cnt_q <= inh_cnt_q + IW'(1);
                    end
                end
                ST_REQ: begin
                    clk_oe_q <= 1'b0;
                    if (fall) begin
                        dat_oe_q  <= ~byte_q[0];
                        bit_cnt_q <= 4'd1;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            // Odd parity bit is 1 for an even count of ones, so the pull-down is the plain XOR.
                            dat_oe_q <= ^byte_q;
                            state_q  <= ST_PARITY;
                        end else begin
                            dat_oe_q  <= ~byte_q[bit_cnt_q[2:0]];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (fall) begin
                        dat_oe_q <= 1'b0;
                        state_q  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (fall) begin
                        if (!dat_q) begin
                            state_q <= ST_RELEASE;
                        end else begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (clk_f_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase

`ifdef PS2_TX_TIMEOUT_EN
            if (state_q inside {ST_REQ, ST_SHIFT, ST_PARITY, ST_STOP}) begin
                if (tmo_cnt_q == TMO_LIMIT) begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    err_q    <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end else begin
                    tmo_cnt_q <= tmo_cnt_q + 18'd1;
                end
            end else begin
                tmo_cnt_q <= '0;
            end
`endif
        end
    end

    assign clkOe   = clk_oe_q;
    assign datOe   = dat_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = err_q;
    assign state_o = state_q;

endmodule
